// File: rtl/ttseq_pkg.sv
// Shared types and helpers for the truth-table sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ttseq_pkg;

    // Sweep control states; encoding is fixed so it can be probed in the lab.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_SETTLE = 2;

    // Number of input vectors for an n_in-input function.
    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/ttseq_settle_cnt.sv
// Settle-time up-counter with terminal-count flag.
// Latency: tc is combinational from the count register; clr/en act on the next edge.
// Backpressure: none; the counter holds when en is low and stops counting itself is the caller's job.
// Ports: clk, rst (sync, active-high), clr (sync clear, wins over en), en (count up), tc (count == TERM).
module ttseq_settle_cnt #(
    parameter int W    = 1,
    parameter int TERM = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == TERM_V);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input vector of an N_IN-input function unit and checks f against EXPECT.
// Latency: each vector takes SETTLE+1 cycles; done rises N_VEC*(SETTLE+1) edges after start.
// Backpressure: none; start is ignored while busy, abort cancels in any state.
// Ports: clk, rst (sync, active-high), start, abort, f_in in; vec_out, busy, done, pass,
//        err_cnt, fail_valid, first_fail out; observed out only when TTSEQ_CAPTURE_EN is defined.
module truth_table_sequencer
    import ttseq_pkg::*;
#(
    parameter int                   N_IN   = 4,
    parameter logic [(1<<N_IN)-1:0] EXPECT = '0,
    parameter int                   SETTLE = DEF_SETTLE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     vec_out,
    input  logic                f_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_cnt,
    output logic                fail_valid,
    output logic [N_IN-1:0]     first_fail
`ifdef TTSEQ_CAPTURE_EN
    ,
    output logic [(1<<N_IN)-1:0] observed
`endif
);

    localparam int              N_VEC    = n_vec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(N_VEC);
    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t state, state_nxt;
    logic   settle_tc;
    logic   settle_clr;
    logic   settle_en;
    logic   restart;
    logic   mismatch;

    // start is only honoured when no sweep is running, and abort always wins.
    assign restart  = start && !abort && (state == ST_IDLE || state == ST_DONE);
    assign mismatch = (state == ST_SAMPLE) && (f_in != EXPECT[vec_out]);

    // The counter is parked at zero outside SETTLE, so every SETTLE entry starts
    // from a clean count. It stops at the terminal value so it never overflows.
    assign settle_clr = (state != ST_SETTLE);
    assign settle_en  = (state == ST_SETTLE) && !settle_tc;

    ttseq_settle_cnt #(
        .W    (CW),
        .TERM (SETTLE - 1)
    ) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (settle_clr),
        .en  (settle_en),
        .tc  (settle_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_SETTLE;
                ST_SETTLE:        if (settle_tc) state_nxt = ST_SAMPLE;
                ST_SAMPLE:        state_nxt = (vec_out == LAST_VEC) ? ST_DONE : ST_SETTLE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    // vec_out doubles as the sweep index; it advances on the SAMPLE edge so the
    // next vector is already applied during the first SETTLE cycle.
    always_ff @(posedge clk) begin
        if (rst || abort || restart) begin
            vec_out    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else if (state == ST_SAMPLE) begin
            if (mismatch) begin
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + (N_IN + 1)'(1);
                end
                if (!fail_valid) begin
                    first_fail <= vec_out;
                    fail_valid <= 1'b1;
                end
            end
            if (vec_out != LAST_VEC) begin
                vec_out <= vec_out + N_IN'(1);
            end
        end
    end

`ifdef TTSEQ_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst || abort || restart) begin
            observed <= '0;
        end else if (state == ST_SAMPLE) begin
            observed[vec_out] <= f_in;
        end
    end
`endif

    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: golden/flipped-EXPECT sweeps, abort, reset, busy start, SETTLE=1.
// Latency: n/a.
// Backpressure: n/a.
module tb_truth_table_sequencer;

    // Function unit under test: f = (a & b) | (c ^ d), table for vectors 0..15.
    localparam logic [15:0] GOLDEN   = 16'hF666;
    localparam logic [15:0] EXP_FLIP = 16'hF446; // GOLDEN with bits 5 and 9 flipped

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, start2;
    logic [15:0] mask0;

    logic [3:0]  vec0, vec1, vec2;
    logic        f0, f1, f2;
    logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [4:0]  err0, err1, err2;
    logic        fv0, fv1, fv2;
    logic [3:0]  ff0, ff1, ff2;
`ifdef TTSEQ_CAPTURE_EN
    logic [15:0] obs0, obs1, obs2;
`endif

    function automatic logic fu(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] ^ v[0]);
    endfunction

    // u0 sees a function unit with faults injected at the vectors set in mask0.
    assign f0 = fu(vec0) ^ mask0[vec0];
    assign f1 = fu(vec1);
    assign f2 = fu(vec2);

    truth_table_sequencer #(.N_IN(4), .EXPECT(GOLDEN), .SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec0), .f_in(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_valid(fv0),
        .first_fail(ff0)
`ifdef TTSEQ_CAPTURE_EN
        , .observed(obs0)
`endif
    );

    truth_table_sequencer #(.N_IN(4), .EXPECT(EXP_FLIP), .SETTLE(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec1), .f_in(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_valid(fv1),
        .first_fail(ff1)
`ifdef TTSEQ_CAPTURE_EN
        , .observed(obs1)
`endif
    );

    truth_table_sequencer #(.N_IN(4), .EXPECT(GOLDEN), .SETTLE(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .vec_out(vec2), .f_in(f2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_valid(fv2),
        .first_fail(ff2)
`ifdef TTSEQ_CAPTURE_EN
        , .observed(obs2)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a sweep against fault mask m reports one error per faulty
    // vector and the lowest faulty vector as the first failure.
    function automatic int model_errs(input logic [15:0] m);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int model_first(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic wait_vec0(input logic [3:0] v, input string tag);
        int n = 0;
        while (vec0 != v && n < 100) begin
            tick();
            n++;
        end
        chk(tag, vec0, v);
    endtask

    // One full sweep on u0/u1; optionally pulses start again while busy at vector mid_idx.
    task automatic sweep(input logic [15:0] m, input bit mid_start, input logic [3:0] mid_idx,
                         input string tag);
        int n = 0;
        bit pulsed = 0;
        mask0 = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done0 && n < 200) begin
            if (mid_start && !pulsed && vec0 == mid_idx) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, 48);
        chk({tag, "_err"}, err0, model_errs(m));
        chk({tag, "_fv"}, fv0, (m != 16'h0));
        chk({tag, "_first"}, ff0, model_first(m));
        chk({tag, "_pass"}, pass0, (m == 16'h0));
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_vec"}, vec0, 15);
        chk({tag, "_flip_err"}, err1, 2);
        chk({tag, "_flip_first"}, ff1, 5);
        chk({tag, "_flip_fv"}, fv1, 1);
        chk({tag, "_flip_pass"}, pass1, 0);
        chk({tag, "_flip_done"}, done1, 1);
        chk({tag, "_flip_vec"}, vec1, 15);
        chk({tag, "_flip_busy"}, busy1, 0);
`ifdef TTSEQ_CAPTURE_EN
        chk({tag, "_obs"}, obs0, GOLDEN ^ m);
        chk({tag, "_flip_obs"}, obs1, GOLDEN);
`endif
        tick();
        chk({tag, "_done_hold"}, done0, 1);
        chk({tag, "_err_hold"}, err0, model_errs(m));
    endtask

    initial begin
        int n;
        logic [15:0] m;

        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; mask0 = 16'h0;
        tick();
        tick();
        chk("rst_vec", vec0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_fv", fv0, 0);
        chk("rst_first", ff0, 0);
        rst = 1'b0;
        tick();

        // Golden sweep; u1 simultaneously covers the flipped-EXPECT case.
        sweep(16'h0000, 1'b0, 4'd0, "golden");

        // start while busy at vector 3 must not restart or delay the sweep.
        sweep(16'h0000, 1'b1, 4'd3, "busy_start");

        // Randomised fault patterns, including last-vector and all-vectors boundaries.
        for (int r = 0; r < 6; r++) begin
            m = 16'($urandom);
            if (r == 0) m = 16'h8000;
            if (r == 1) m = 16'hFFFF;
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) tick();
            sweep(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
        end

        // Abort at vector 7 after one error has been recorded.
        mask0 = 16'h0004;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec0(4'd7, "abort_reach7");
        chk("abort_pre_err", err0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_vec", vec0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_err", err0, 0);
        chk("abort_fv", fv0, 0);
        chk("abort_first", ff0, 0);
`ifdef TTSEQ_CAPTURE_EN
        chk("abort_obs", obs0, 0);
`endif
        for (int i = 0; i < 60; i++) tick();
        chk("abort_no_done", done0, 0);

        // abort and start together: abort wins, nothing starts.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy0, 0);
        tick();
        chk("abort_start_vec", vec0, 0);

        // Reset mid-sweep with one error recorded, then a clean sweep.
        mask0 = 16'h0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec0(4'd4, "rst_reach4");
        chk("rst_mid_pre_err", err0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_vec", vec0, 0);
        chk("rst_mid_busy", busy0, 0);
        chk("rst_mid_err", err0, 0);
        chk("rst_mid_fv", fv0, 0);
        chk("rst_mid_first", ff0, 0);
`ifdef TTSEQ_CAPTURE_EN
        chk("rst_mid_obs", obs0, 0);
`endif
        tick();
        sweep(16'h0000, 1'b0, 4'd0, "post_rst");

        // SETTLE=1 with start held high: two cycles per vector, auto-restart after DONE.
        start2 = 1'b1;
        tick();
        n = 0;
        while (!done2 && n < 100) begin
            chk("s1_vec_step", vec2, n >> 1);
            tick();
            n++;
        end
        chk("s1_latency", n, 32);
        chk("s1_pass", pass2, 1);
        chk("s1_err", err2, 0);
        chk("s1_fv", fv2, 0);
        chk("s1_first", ff2, 0);
`ifdef TTSEQ_CAPTURE_EN
        chk("s1_obs", obs2, GOLDEN);
`endif
        tick();
        chk("s1_restart_done", done2, 0);
        chk("s1_restart_busy", busy2, 1);
        chk("s1_restart_vec", vec2, 0);
        start2 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
